// File: rtl/cpu_pkg.sv
// Shared CPU types: forwarding selects, memory-wait FSM states and the PC register index.
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    localparam int unsigned REG_PC = 15;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one E-stage source register; the M result wins over W.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = 4
) (
    input  logic [REG_AW-1:0] ra_e_i,
    input  logic [REG_AW-1:0] wa3_m_i,
    input  logic [REG_AW-1:0] wa3_w_i,
    input  logic              reg_write_m_i,
    input  logic              reg_write_w_i,
    output logic [1:0]        fwd_o
);

    fwd_sel_e sel;

    // The PC is never produced by the ALU/load path, so it always comes from the register file.
    always_comb begin
        sel = FWD_RF;
        if (ra_e_i != REG_AW'(REG_PC)) begin
            if (reg_write_m_i && (ra_e_i == wa3_m_i)) begin
                sel = FWD_MEM;
            end else if (reg_write_w_i && (ra_e_i == wa3_w_i)) begin
                sel = FWD_WB;
            end
        end
    end

    assign fwd_o = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use/branch/memory stalls and flushes.
// Define HAZARD_PERF_EN to add the StallCnt/FlushCnt performance counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
    ,
    parameter int unsigned CNT_W       = 16
`endif
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] RA1E,
    input  logic [REG_AW-1:0] RA2E,
    input  logic [REG_AW-1:0] WA3E,
    input  logic [REG_AW-1:0] WA3M,
    input  logic [REG_AW-1:0] WA3W,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              BranchTakenE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              MemErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
`endif
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_err_q, mem_err_d;
    logic          ldstall;
    logic          mem_stall;

    fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .ra_e_i        (RA1E),
        .wa3_m_i       (WA3M),
        .wa3_w_i       (WA3W),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardAE)
    );

    fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .ra_e_i        (RA2E),
        .wa3_m_i       (WA3M),
        .wa3_w_i       (WA3W),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (ForwardBE)
    );

    assign ldstall   = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
    // Combinational so the freeze starts in the request cycle; a timed-out memory never stalls again.
    assign mem_stall = MemReqM && !MemReadyM && !mem_err_q;

    assign StallF = ldstall || mem_stall;
    assign StallD = ldstall || mem_stall;
    assign StallE = mem_stall;
    assign StallM = mem_stall;
    assign FlushW = mem_stall;
    assign FlushE = (ldstall || BranchTakenE) && !mem_stall;
    assign FlushD = BranchTakenE && !mem_stall;
    assign MemErr = mem_err_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            MEM_IDLE: begin
                if (MemReqM && !MemReadyM && !mem_err_q) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d    = MEM_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    if (wait_cnt_q != CW'(MEM_TIMEOUT)) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    // Abandon the access: flag the error and let the pipeline run on.
                    if (wait_cnt_d == CW'(MEM_TIMEOUT)) begin
                        mem_err_d  = 1'b1;
                        state_d    = MEM_IDLE;
                        wait_cnt_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= MEM_IDLE;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (FlushD && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then randomized traffic against a reference model.
module tb_hazard_ctrl;

    localparam int unsigned MEM_TO = 4;

    typedef struct packed {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwm, rww, mtr, br, req, rdy;
    } in_t;

    typedef struct packed {
        logic [1:0]  fa, fb;
        logic        sf, sd, se, sm, fd, fe, fw, err;
`ifdef HAZARD_PERF_EN
        logic [15:0] sc, fc;
`endif
    } out_t;

    logic       CLK, Reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_PERF_EN
    logic [15:0] StallCnt, FlushCnt;
`endif

    hazard_ctrl #(
        .REG_AW      (4),
        .MEM_TIMEOUT (MEM_TO)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .BranchTakenE (BranchTakenE),
        .MemReqM      (MemReqM),
        .MemReadyM    (MemReadyM),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .MemErr       (MemErr)
`ifdef HAZARD_PERF_EN
        ,
        .StallCnt     (StallCnt),
        .FlushCnt     (FlushCnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state: sticky error, whether an access is outstanding and for how long.
    bit          m_err;
    bit          m_waiting;
    int          m_waited;
    int unsigned m_stalls, m_flushes;

    out_t sb_q[$];
    int   n_pass, n_checks, n_cyc;

    function automatic logic [1:0] fwd_ref(logic [3:0] ra, in_t v);
        if (ra == 4'd15) return 2'b00;
        if (v.rwm && ra == v.wa3m) return 2'b10;
        if (v.rww && ra == v.wa3w) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t model_out(in_t v);
        out_t o;
        bit   load_use, frozen;
        load_use = v.mtr && (v.ra1d == v.wa3e || v.ra2d == v.wa3e);
        frozen   = v.req && !v.rdy && !m_err;
        o.fa  = fwd_ref(v.ra1e, v);
        o.fb  = fwd_ref(v.ra2e, v);
        o.sf  = load_use || frozen;
        o.sd  = load_use || frozen;
        o.se  = frozen;
        o.sm  = frozen;
        o.fw  = frozen;
        o.fe  = (load_use || v.br) && !frozen;
        o.fd  = v.br && !frozen;
        o.err = m_err;
`ifdef HAZARD_PERF_EN
        o.sc  = 16'(m_stalls);
        o.fc  = 16'(m_flushes);
`endif
        return o;
    endfunction

    task automatic model_reset();
        m_err     = 0;
        m_waiting = 0;
        m_waited  = 0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    task automatic model_step(in_t v, out_t o);
        if (o.sf && m_stalls < 32'hffff) m_stalls++;
        if (o.fd && m_flushes < 32'hffff) m_flushes++;
        if (!m_waiting) begin
            if (v.req && !v.rdy && !m_err) begin
                m_waiting = 1;
                m_waited  = 1;
            end
        end else if (v.rdy) begin
            m_waiting = 0;
        end else begin
            m_waited++;
            if (m_waited >= MEM_TO) begin
                m_err     = 1;
                m_waiting = 0;
            end
        end
    endtask

    // Called just after a rising edge; applies one cycle of stimulus and queues the expected outputs.
    task automatic drive(input bit rst, input in_t v);
        out_t e;
        Reset        = rst;
        RA1D         = v.ra1d;
        RA2D         = v.ra2d;
        RA1E         = v.ra1e;
        RA2E         = v.ra2e;
        WA3E         = v.wa3e;
        WA3M         = v.wa3m;
        WA3W         = v.wa3w;
        RegWriteM    = v.rwm;
        RegWriteW    = v.rww;
        MemtoRegE    = v.mtr;
        BranchTakenE = v.br;
        MemReqM      = v.req;
        MemReadyM    = v.rdy;
        if (rst) model_reset();
        e = model_out(v);
        sb_q.push_back(e);
        @(posedge CLK);
        if (!rst) model_step(v, e);
        #1;
    endtask

    function automatic logic [3:0] pick_reg();
        if ($urandom_range(0, 4) == 0) return 4'd15;
        return 4'($urandom_range(0, 5));
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.ra1d = pick_reg();
        v.ra2d = pick_reg();
        v.ra1e = pick_reg();
        v.ra2e = pick_reg();
        v.wa3e = pick_reg();
        v.wa3m = pick_reg();
        v.wa3w = pick_reg();
        v.rwm  = 1'($urandom_range(0, 1));
        v.rww  = 1'($urandom_range(0, 1));
        v.mtr  = ($urandom_range(0, 9) < 3);
        v.br   = ($urandom_range(0, 9) < 2);
        v.req  = ($urandom_range(0, 9) < 5);
        v.rdy  = ($urandom_range(0, 9) < 3);
        return v;
    endfunction

    out_t act, exp_o;
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_o  = sb_q.pop_front();
            act.fa  = ForwardAE;
            act.fb  = ForwardBE;
            act.sf  = StallF;
            act.sd  = StallD;
            act.se  = StallE;
            act.sm  = StallM;
            act.fd  = FlushD;
            act.fe  = FlushE;
            act.fw  = FlushW;
            act.err = MemErr;
`ifdef HAZARD_PERF_EN
            act.sc  = StallCnt;
            act.fc  = FlushCnt;
`endif
            n_checks++;
            if (act === exp_o) begin
                n_pass++;
            end else begin
                $display("FAIL cycle%0d outputs act=%h exp=%h (fa fb sf sd se sm fd fe fw err)",
                         n_cyc, act, exp_o);
            end
            n_cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        in_t v;
        n_pass   = 0;
        n_checks = 0;
        n_cyc    = 0;
        model_reset();
        v = '0;
        Reset = 1'b1;
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM} = '0;
        @(posedge CLK);
        #1;
        drive(1, v);
        drive(1, v);
        drive(0, v);

        // Forwarding priority and PC exclusion
        v.ra1e = 4'd3; v.ra2e = 4'd3; v.wa3m = 4'd3; v.wa3w = 4'd3; v.rwm = 1; v.rww = 1;
        drive(0, v);
        v.rwm = 0;
        drive(0, v);
        v.ra1e = 4'd15; v.rwm = 1;
        drive(0, v);
        v = '0;

        // Load-use hit then miss
        v.mtr = 1; v.wa3e = 4'd5; v.ra2d = 4'd5; v.ra1d = 4'd1;
        drive(0, v);
        v.ra2d = 4'd6;
        drive(0, v);
        v = '0;

        v.br = 1;
        drive(0, v);
        v = '0;

        // Three-cycle memory wait
        v.req = 1;
        repeat (3) drive(0, v);
        v.rdy = 1;
        drive(0, v);
        v = '0;
        drive(0, v);

        // Timeout: error is sticky and stalls stay down until reset
        v.req = 1;
        repeat (7) drive(0, v);
        drive(1, v);
        drive(0, v);

        // Branch during a memory freeze is deferred to the release cycle
        v = '0;
        drive(1, v);
        v.req = 1; v.br = 1;
        repeat (3) drive(0, v);
        v.rdy = 1;
        drive(0, v);
        v = '0;
        drive(0, v);
        drive(0, v);

        for (int blk = 0; blk < 6; blk++) begin
            drive(1, rand_in());
            for (int c = 0; c < 150; c++) drive(0, rand_in());
        end

        @(negedge CLK);
        #1;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
